// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - DES round-key generator (PC-1, C/D rotation, PC-2); optional KEY_PARITY_CHECK_EN adds parity_err
module des_key_schedule (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        key_load,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        advance,
    output logic [47:0] round_key,
    output logic [3:0]  round_num,
    output logic        key_valid,
    output logic        last_round
`ifdef KEY_PARITY_CHECK_EN
    ,
    output logic        parity_err
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // FIPS bit n of a W-bit vector lives at index W-n.
    function automatic logic [55:0] pc1_f(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic by_two);
        return by_two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic by_two);
        return by_two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        dir_q, dir_d;
    logic [3:0]  round_q, round_d;
    logic [55:0] pc1_key;
    logic [4:0]  next_j;
    logic        shift_two;

    assign pc1_key = pc1_f(key_in);

    // Round whose shift is applied on the next advance: j=r+2 forward, j=16-r backward.
    assign next_j    = dir_q ? (5'd16 - {1'b0, round_q}) : ({1'b0, round_q} + 5'd2);
    assign shift_two = !(next_j == 5'd1 || next_j == 5'd2 || next_j == 5'd9 || next_j == 5'd16);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        dir_d   = dir_q;
        round_d = round_q;
        if (key_load) begin
            state_d = RUN;
            dir_d   = decrypt;
            round_d = 4'd0;
            c_d     = decrypt ? pc1_key[55:28] : rotl(pc1_key[55:28], 1'b0);
            d_d     = decrypt ? pc1_key[27:0]  : rotl(pc1_key[27:0], 1'b0);
        end else if (state_q == RUN && advance) begin
            if (round_q == 4'd15) begin
                state_d = IDLE;
                round_d = 4'd0;
            end else begin
                round_d = round_q + 4'd1;
                c_d     = dir_q ? rotr(c_q, shift_two) : rotl(c_q, shift_two);
                d_d     = dir_q ? rotr(d_q, shift_two) : rotl(d_q, shift_two);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            dir_q   <= 1'b0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dir_q   <= dir_d;
            round_q <= round_d;
        end
    end

    assign key_valid  = (state_q == RUN);
    assign round_num  = round_q;
    assign last_round = key_valid && (round_q == 4'd15);
    assign round_key  = key_valid ? pc2_f({c_q, d_q}) : 48'h0;

`ifdef KEY_PARITY_CHECK_EN
    // DES key bytes must have odd parity; any even byte flags the key.
    function automatic logic any_even_byte(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) bad = bad | ~(^k[b*8 +: 8]);
        return bad;
    endfunction

    logic parity_err_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)        parity_err_q <= 1'b0;
        else if (key_load) parity_err_q <= any_even_byte(key_in);
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - randomized and directed bench for des_key_schedule against a FIPS 46-3 key model
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        key_load = 1'b0;
    logic [63:0] key_in = '0;
    logic        decrypt = 1'b0;
    logic        advance = 1'b0;
    logic [47:0] round_key;
    logic [3:0]  round_num;
    logic        key_valid;
    logic        last_round;
`ifdef KEY_PARITY_CHECK_EN
    logic        parity_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] TKEY = 64'h133457799BBCDFF1;

    des_key_schedule dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .key_load   (key_load),
        .key_in     (key_in),
        .decrypt    (decrypt),
        .advance    (advance),
        .round_key  (round_key),
        .round_num  (round_num),
        .key_valid  (key_valid),
        .last_round (last_round)
`ifdef KEY_PARITY_CHECK_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int SHIFTS [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Subkey Ki straight from the standard: total left rotation of the PC-1 halves, then PC-2.
    function automatic logic [47:0] subkey(input logic [63:0] key, input int i);
        bit c [1:28];
        bit d [1:28];
        bit cd [1:56];
        int cum;
        logic [47:0] r;
        cum = 0;
        for (int j = 0; j < i; j++) cum += SHIFTS[j];
        for (int k = 1; k <= 28; k++) begin
            c[k] = key[64 - PC1[k - 1]];
            d[k] = key[64 - PC1[k + 27]];
        end
        for (int k = 1; k <= 28; k++) begin
            cd[k]      = c[((k - 1 + cum) % 28) + 1];
            cd[k + 28] = d[((k - 1 + cum) % 28) + 1];
        end
        r = '0;
        for (int n = 0; n < 48; n++) r[47 - n] = cd[PC2[n]];
        return r;
    endfunction

    logic [47:0] m_sched [0:15];
    logic        m_valid = 1'b0;
    logic [3:0]  m_idx = 4'd0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_valid = 1'b0;
            m_idx   = 4'd0;
        end else if (key_load) begin
            for (int r = 0; r < 16; r++) m_sched[r] = subkey(key_in, decrypt ? 16 - r : r + 1);
            m_valid = 1'b1;
            m_idx   = 4'd0;
        end else if (advance && m_valid) begin
            if (m_idx == 4'd15) begin
                m_valid = 1'b0;
                m_idx   = 4'd0;
            end else begin
                m_idx = m_idx + 4'd1;
            end
        end
    end

    always @(negedge clk) begin
        logic [47:0] exp_key;
        logic        exp_last;
        exp_key  = m_valid ? m_sched[m_idx] : 48'h0;
        exp_last = m_valid && (m_idx == 4'd15);
        n_checks++;
        if (round_key !== exp_key || key_valid !== m_valid || round_num !== m_idx || last_round !== exp_last) begin
            n_errors++;
            $display("FAIL cycle_cmp t=%0t got key=%h valid=%b rnd=%0d last=%b expected key=%h valid=%b rnd=%0d last=%b",
                     $time, round_key, key_valid, round_num, last_round, exp_key, m_valid, m_idx, exp_last);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input logic ld, input logic [63:0] k, input logic dec, input logic adv);
        @(negedge clk);
        key_load = ld;
        key_in   = k;
        decrypt  = dec;
        advance  = adv;
    endtask

    initial begin
        chk("model_k1", 64'(subkey(TKEY, 1)), 64'h1B02EFFC7072);
        chk("model_k2", 64'(subkey(TKEY, 2)), 64'h79AED9DBC9E5);
        chk("model_k16", 64'(subkey(TKEY, 16)), 64'hCB3D8B0E17F5);

        tick(0, '0, 0, 1);
        tick(0, '0, 0, 1);
        chk("reset_valid", 64'(key_valid), 64'd0);
        chk("reset_key", 64'(round_key), 64'd0);
        n_rst = 1'b1;
        tick(0, '0, 0, 1);
        tick(0, '0, 0, 0);
        chk("idle_adv_ignored", 64'(key_valid), 64'd0);

        tick(1, TKEY, 0, 0);
        tick(0, '0, 0, 1);
        chk("enc_k1", 64'(round_key), 64'h1B02EFFC7072);
        chk("enc_r0", 64'(round_num), 64'd0);
        tick(0, '0, 0, 0);
        chk("enc_k2", 64'(round_key), 64'h79AED9DBC9E5);

        tick(1, TKEY, 1, 0);
        tick(0, '0, 0, 0);
        chk("dec_k16", 64'(round_key), 64'hCB3D8B0E17F5);
        repeat (15) tick(0, '0, 0, 1);
        tick(0, '0, 0, 1);
        chk("dec_k1", 64'(round_key), 64'h1B02EFFC7072);
        chk("dec_last", 64'(last_round), 64'd1);
        tick(0, '0, 0, 0);
        chk("dec_done_valid", 64'(key_valid), 64'd0);
        chk("dec_done_key", 64'(round_key), 64'd0);

        tick(1, TKEY, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tick(0, '0, 0, 1);
            chk("held_rnd", 64'(round_num), 64'(i));
            if (i == 15) chk("held_k16", 64'(round_key), 64'hCB3D8B0E17F5);
        end
        tick(0, '0, 0, 0);
        chk("held_idle", 64'(key_valid), 64'd0);

        tick(1, TKEY, 0, 0);
        repeat (7) tick(0, '0, 0, 1);
        tick(1, 64'h0, 0, 1);
        chk("prio_r7", 64'(round_num), 64'd7);
        tick(0, '0, 0, 0);
        chk("prio_rnd", 64'(round_num), 64'd0);
        chk("prio_key", 64'(round_key), 64'd0);
        chk("prio_valid", 64'(key_valid), 64'd1);

        tick(1, TKEY, 0, 0);
        repeat (5) tick(0, '0, 0, 1);
        tick(0, '0, 0, 0);
        chk("rst_r5", 64'(round_num), 64'd5);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(key_valid), 64'd0);
        chk("async_rst_key", 64'(round_key), 64'd0);
        chk("async_rst_rnd", 64'(round_num), 64'd0);
        tick(0, '0, 0, 1);
        n_rst = 1'b1;
        repeat (3) tick(0, '0, 0, 1);
        chk("post_rst_idle", 64'(key_valid), 64'd0);

`ifdef KEY_PARITY_CHECK_EN
        tick(1, TKEY, 0, 0);
        tick(0, '0, 0, 0);
        chk("parity_ok", 64'(parity_err), 64'd0);
        tick(1, 64'h0, 0, 0);
        tick(0, '0, 0, 0);
        chk("parity_bad", 64'(parity_err), 64'd1);
`endif

        for (int c = 0; c < 800; c++) begin
            tick(($urandom_range(0, 19) == 0), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0));
        end
        tick(0, '0, 0, 0);
        tick(0, '0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
